vga_timing_gen: RTL

Parametrised VGA timing generator. It succeeds the fixed 640x480 divide-by-2 sync path and generalises mode timing, sync polarity, pixel-clock divide ratio and counter width. It produces sync, blank and pixel-position outputs plus line and frame strobes, clocked from the system clock with a pixel-rate enable. It sits between the system clock domain and the VGA DAC and feeds pixel coordinates to the framebuffer/GPU readout.

---
 rtl/vga_timing_gen.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync, blank, pixel position, line/frame strobes.
// Optional: define VGA_FRAME_CNT_EN to add a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int H_POL  = 0,
   parameter int V_POL  = 0,
   parameter int DIV    = 2,
   parameter int CW     = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          vga_clk,
   output logic          pix_en,
   output logic          h_sync,
   output logic          v_sync,
   output logic          blank_n,
   output logic          sync_n,
   output logic [CW-1:0] pos_x,
   output logic [CW-1:0] pos_y,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

   // Region bounds carry one extra bit so a bound equal to 2^CW still compares correctly.
   localparam logic [CW:0] H_VIS_W = (CW+1)'(H_VIS);
   localparam logic [CW:0] H_SS_W  = (CW+1)'(H_VIS + H_FP);
   localparam logic [CW:0] H_SE_W  = (CW+1)'(H_VIS + H_FP + H_SYNC);
   localparam logic [CW:0] V_VIS_W = (CW+1)'(V_VIS);
   localparam logic [CW:0] V_SS_W  = (CW+1)'(V_VIS + V_FP);
   localparam logic [CW:0] V_SE_W  = (CW+1)'(V_VIS + V_FP + V_SYNC);

   localparam logic H_ACT = (H_POL != 0);
   localparam logic V_ACT = (V_POL != 0);

   logic          run_q, run_d;
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic          line_start_d, frame_start_d;

   logic          pix_en_q, h_sync_q, v_sync_q, blank_n_q, vga_clk_q;
   logic          line_start_q, frame_start_q;
   logic [CW-1:0] pos_x_q, pos_y_q;

   logic          pix_en_d, h_sync_d, v_sync_d, blank_n_d, vga_clk_d;
   logic [CW-1:0] pos_x_d, pos_y_d;
   logic          h_vis, v_vis, h_in_sync, v_in_sync, clk_phase;

   // run_q low means the next enabled edge is a restart at the origin, not an advance.
   always_comb begin
      // NOTE: every variable gets a default first so no path can leave it unassigned (no latches).
      run_d         = run_q;
      div_d         = div_q;
      h_d           = h_q;
      v_d           = v_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (!en) begin
         run_d = 1'b0;
         div_d = '0;
         h_d   = '0;
         v_d   = '0;
      end else if (!run_q) begin
         run_d         = 1'b1;
         div_d         = '0;
         h_d           = '0;
         v_d           = '0;
         line_start_d  = 1'b1;
         frame_start_d = 1'b1;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         if (h_q == H_LAST) begin
            h_d          = '0;
            line_start_d = 1'b1;
            if (v_q == V_LAST) begin
               v_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   if (DIV >= 2) begin : g_div_clk
      assign clk_phase = (div_d < DW'(DIV / 2));
   end else begin : g_no_div_clk
      assign clk_phase = 1'b0;
   end

   // Outputs decode the next counter values so they land on the same edge as the counters.
   always_comb begin
      h_vis     = ({1'b0, h_d} < H_VIS_W);
      v_vis     = ({1'b0, v_d} < V_VIS_W);
      h_in_sync = ({1'b0, h_d} >= H_SS_W) && ({1'b0, h_d} < H_SE_W);
      v_in_sync = ({1'b0, v_d} >= V_SS_W) && ({1'b0, v_d} < V_SE_W);
      blank_n_d = run_d && h_vis && v_vis;
      pos_x_d   = blank_n_d ? h_d : '0;
      pos_y_d   = blank_n_d ? v_d : '0;
      h_sync_d  = (run_d && h_in_sync) ? H_ACT : ~H_ACT;
      v_sync_d  = (run_d && v_in_sync) ? V_ACT : ~V_ACT;
      pix_en_d  = run_d && (div_d == DIV_LAST);
      vga_clk_d = run_d && clk_phase;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q         <= 1'b0;
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         pix_en_q      <= 1'b0;
         h_sync_q      <= ~H_ACT;
         v_sync_q      <= ~V_ACT;
         blank_n_q     <= 1'b0;
         vga_clk_q     <= 1'b0;
         pos_x_q       <= '0;
         pos_y_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         run_q         <= run_d;
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         pix_en_q      <= pix_en_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         blank_n_q     <= blank_n_d;
         vga_clk_q     <= vga_clk_d;
         pos_x_q       <= pos_x_d;
         pos_y_q       <= pos_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_clk     = vga_clk_q;
   assign pix_en      = pix_en_q;
   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign blank_n     = blank_n_q;
   assign sync_n      = 1'b0;
   assign pos_x       = pos_x_q;
   assign pos_y       = pos_y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Restart frames (run_q low) do not count; the counter freezes while en is low.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_start_d && run_q) frame_cnt_d = frame_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) frame_cnt_q <= 16'd0;
      else      frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule
